adc_spi_streamer: RTL and testbench

ADC_SPI_STREAMER -- requirements
Module: adc_spi_streamer

---
 rtl/adc_spi_streamer.sv | 153 +++++++++++++++
 tb/tb_adc_spi_streamer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_streamer.sv
// ADC sample FIFO drained over an SPI slave port, one 16-bit frame per chip-select.
// Optional STREAMER_STATUS_EN adds sticky overflow/underrun flags with clr_flags.
`timescale 1ns/1ps

module adc_spi_streamer #(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sample_data,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic        sclk,
    input  logic        SPI_cs,
    output logic        processed_MISO,
    output logic        SPI_RDY,
    output logic [1:0]  dbg_state
`ifdef STREAMER_STATUS_EN
    ,
    input  logic        clr_flags,
    output logic        overflow,
    output logic        underrun
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Handshake: a sample transfers on any clk edge where sample_valid and
    // sample_ready are both high; sample_ready is sampled before that edge's pop.

    state_t          state_q;
    state_t          state_d;
    logic [15:0]     mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic [15:0]     shreg;
    logic [4:0]      bit_cnt;
    logic            spi_rdy_q;
    logic [SYNC_STAGES:0] sclk_pipe;
    logic [SYNC_STAGES:0] cs_pipe;
    logic            sclk_s;
    logic            cs_s;
    logic            sclk_fall;
    logic            cs_fall;
    logic            cs_rise;

    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push         = sample_valid && !full;
    assign pop          = (state_q == LOAD) && !empty;
    assign sample_ready = !full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= sample_data;
    end

    // Top bit of each pipe is the edge-detect flop; the bit below it is the synchronized level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_pipe <= '1;
            cs_pipe   <= '1;
        end else begin
            sclk_pipe <= {sclk_pipe[SYNC_STAGES-1:0], sclk};
            cs_pipe   <= {cs_pipe[SYNC_STAGES-1:0], SPI_cs};
        end
    end

    assign sclk_s    = sclk_pipe[SYNC_STAGES-1];
    assign cs_s      = cs_pipe[SYNC_STAGES-1];
    assign sclk_fall = sclk_pipe[SYNC_STAGES] && !sclk_s;
    assign cs_fall   = cs_pipe[SYNC_STAGES] && !cs_s;
    assign cs_rise   = !cs_pipe[SYNC_STAGES] && cs_s;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = LOAD;
            LOAD:    state_d = cs_rise ? IDLE : SHIFT;
            SHIFT: begin
                if (cs_rise)                            state_d = IDLE;
                else if (sclk_fall && bit_cnt == 5'd15) state_d = DONE;
            end
            DONE:    if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // An aborted LOAD still pops: the frame is treated as consumed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (state_q == LOAD) begin
            shreg   <= empty ? 16'h0000 : mem[rd_ptr[AW-1:0]];
            bit_cnt <= '0;
        end else if (state_q == SHIFT && sclk_fall && !cs_rise) begin
            shreg   <= {shreg[14:0], 1'b0};
            bit_cnt <= bit_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) spi_rdy_q <= 1'b0;
        else      spi_rdy_q <= (state_q == IDLE) && !empty && cs_s;
    end

    assign SPI_RDY        = spi_rdy_q;
    assign processed_MISO = (state_q == SHIFT) ? shreg[15] : 1'b0;
    assign dbg_state      = state_q;

`ifdef STREAMER_STATUS_EN
    // Set events take priority over clr_flags in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (sample_valid && full) overflow <= 1'b1;
            else if (clr_flags)       overflow <= 1'b0;
            if (state_q == LOAD && empty) underrun <= 1'b1;
            else if (clr_flags)           underrun <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_adc_spi_streamer.sv
// Self-checking bench for adc_spi_streamer: a queue model of the FIFO predicts every SPI frame.
`timescale 1ns/1ps

module tb_adc_spi_streamer;
    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        sclk;
    logic        SPI_cs;
    logic        processed_MISO;
    logic        SPI_RDY;
    logic [1:0]  dbg_state;
`ifdef STREAMER_STATUS_EN
    logic        clr_flags;
    logic        overflow;
    logic        underrun;
`endif

    int          n_checks;
    int          n_fail;
    logic [15:0] exp_q[$];
    logic [15:0] frame_exp;
    logic        exp_ovf;
    logic        exp_unf;

    adc_spi_streamer #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .sclk           (sclk),
        .SPI_cs         (SPI_cs),
        .processed_MISO (processed_MISO),
        .SPI_RDY        (SPI_RDY),
        .dbg_state      (dbg_state)
`ifdef STREAMER_STATUS_EN
        ,
        .clr_flags      (clr_flags),
        .overflow       (overflow),
        .underrun       (underrun)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_sample(input logic [15:0] d);
        @(negedge clk);
        check_eq("ready_pre", {31'd0, sample_ready}, {31'd0, exp_q.size() < DEPTH});
        sample_data  = d;
        sample_valid = 1'b1;
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else                      exp_ovf = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // Master side: sclk idles low, MISO is sampled just before each rise.
    task automatic spi_frame(input int nbits, output logic [15:0] rd);
        rd = '0;
        @(negedge clk);
        check_eq("rdy_pre", {31'd0, SPI_RDY}, {31'd0, exp_q.size() != 0});
        check_eq("miso_idle", {31'd0, processed_MISO}, 32'd0);
        if (exp_q.size() != 0) frame_exp = exp_q.pop_front();
        else begin
            frame_exp = 16'h0000;
            exp_unf   = 1'b1;
        end
        SPI_cs = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rdy_in_frame", {31'd0, SPI_RDY}, 32'd0);
        for (int i = 0; i < nbits; i++) begin
            rd   = {rd[14:0], processed_MISO};
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic spi_end();
        SPI_cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic full_frame();
        logic [15:0] rd;
        spi_frame(16, rd);
        check_eq("miso_done", {31'd0, processed_MISO}, 32'd0);
        check_eq("frame_data", {16'd0, rd}, {16'd0, frame_exp});
        spi_end();
    endtask

`ifdef STREAMER_STATUS_EN
    task automatic check_flags();
        check_eq("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        check_eq("underrun", {31'd0, underrun}, {31'd0, exp_unf});
    endtask

    task automatic clear_flags();
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
        check_flags();
    endtask
`endif

    initial begin
        logic [15:0] rd;
        int          lvl;
        n_checks     = 0;
        n_fail       = 0;
        exp_ovf      = 1'b0;
        exp_unf      = 1'b0;
        frame_exp    = '0;
        rst          = 1'b0;
        sample_data  = '0;
        sample_valid = 1'b0;
        sclk         = 1'b0;
        SPI_cs       = 1'b1;
`ifdef STREAMER_STATUS_EN
        clr_flags    = 1'b0;
`endif
        repeat (4) @(negedge clk);
        check_eq("rst_ready", {31'd0, sample_ready}, 32'd1);
        check_eq("rst_rdy", {31'd0, SPI_RDY}, 32'd0);
        check_eq("rst_miso", {31'd0, processed_MISO}, 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // single sample, SPI_RDY latency
        push_sample(16'hA5C3);
        check_eq("rdy_edge_n", {31'd0, SPI_RDY}, 32'd0);
        @(negedge clk);
        check_eq("rdy_edge_n1", {31'd0, SPI_RDY}, 32'd1);
        full_frame();
        check_eq("rdy_after", {31'd0, SPI_RDY}, 32'd0);

        // fill to full, drop one, drain in order
        for (int i = 1; i <= DEPTH; i++) push_sample(16'(i));
        @(negedge clk);
        check_eq("full_ready", {31'd0, sample_ready}, 32'd0);
        push_sample(16'hFFFF);
`ifdef STREAMER_STATUS_EN
        check_flags();
`endif
        for (int i = 0; i < DEPTH; i++) full_frame();
`ifdef STREAMER_STATUS_EN
        check_flags();
        clear_flags();
`endif

        // empty frame reads zeros
        full_frame();
`ifdef STREAMER_STATUS_EN
        check_flags();
        clear_flags();
`endif

        // aborted frame after 5 bits still consumes the sample
        push_sample(16'h1234);
        push_sample(16'h5678);
        spi_frame(5, rd);
        check_eq("abort_bits", {27'd0, rd[4:0]}, {27'd0, frame_exp[15:11]});
        spi_end();
        full_frame();

        // random pushes with interleaved reads across pointer wrap
        for (int i = 0; i < 40; i++) begin
            push_sample(16'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                lvl = exp_q.size();
                if (lvl >= 1 && lvl <= DEPTH - 2) begin
                    fork
                        full_frame();
                        begin
                            repeat ($urandom_range(2, 12)) @(negedge clk);
                            push_sample(16'($urandom));
                        end
                    join
                end else begin
                    full_frame();
                end
            end
        end
        while (exp_q.size() != 0) full_frame();
`ifdef STREAMER_STATUS_EN
        check_flags();
`endif

        // reset in the middle of a frame
        push_sample(16'hBEEF);
        push_sample(16'h0F0F);
        push_sample(16'h7001);
        spi_frame(8, rd);
        check_eq("pre_rst_bits", {24'd0, rd[7:0]}, {24'd0, frame_exp[15:8]});
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_miso", {31'd0, processed_MISO}, 32'd0);
        check_eq("rst_mid_rdy", {31'd0, SPI_RDY}, 32'd0);
        check_eq("rst_mid_ready", {31'd0, sample_ready}, 32'd1);
        SPI_cs = 1'b1;
        sclk   = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
`ifdef STREAMER_STATUS_EN
        check_flags();
`endif
        rst = 1'b1;
        repeat (4) @(negedge clk);
        full_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
